// File: rtl/pipe_stage_track.sv
// pipe_stage_track: generic elastic pipeline of DEPTH register stages.
// Each stage carries valid, payload and a writeback tag (wen, waddr).
// Stage 0 is the youngest and stage DEPTH-1 the oldest.
// Supported features:
//   - per-stage stall with bubble collapse (an empty stage never holds)
//   - ranged flush (bit k kills stages 0..k)
//   - sink backpressure
//   - a two-port RAW hazard lookup across all in-flight stages
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_*          upstream handshake, payload and tag
//   stall_req[i]                    word in stage i must not advance
//   flush[k]                        kill stages 0..k at the next edge
//   out_valid/out_ready/out_*       oldest stage towards the sink
//   stage_valid/stage_wen/stage_waddr  per-stage status for decode logic
//   query_a/b -> hit_*, hit_stage_*, hit_data_*  youngest matching producer
module pipe_stage_track #(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    localparam int HS_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_wen,
    input  logic [ADDR_W-1:0]        in_waddr,
    input  logic [DEPTH-1:0]         stall_req,
    input  logic [DEPTH-1:0]         flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_wen,
    output logic [ADDR_W-1:0]        out_waddr,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH-1:0]         stage_wen,
    output logic [DEPTH*ADDR_W-1:0]  stage_waddr,
    input  logic [ADDR_W-1:0]        query_a,
    input  logic [ADDR_W-1:0]        query_b,
    output logic                     hit_a,
    output logic                     hit_b,
    output logic [HS_W-1:0]          hit_stage_a,
    output logic [HS_W-1:0]          hit_stage_b,
    output logic [DATA_W-1:0]        hit_data_a,
    output logic [DATA_W-1:0]        hit_data_b
);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  wen_r;
    logic [DATA_W-1:0] data_r  [DEPTH];
    logic [ADDR_W-1:0] waddr_r [DEPTH];

    logic [DEPTH-1:0]  hold_s;
    logic [DEPTH-1:0]  kill_s;
    logic              in_ready_s;
    logic [ADDR_W*DEPTH-1:0] stage_waddr_s;
    logic              hit_a_s, hit_b_s;
    logic [HS_W-1:0]   hit_stage_a_s, hit_stage_b_s;
    logic [DATA_W-1:0] hit_data_a_s, hit_data_b_s;

    // A stage is a producer for the query when it is live, writes back, and the
    // address matches; register 0 is excluded when it is hardwired to zero.
    function automatic logic match_f(input logic v, input logic w,
                                     input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] q);
        match_f = v && w && (a == q) &&
                  !((ZERO_REG != 0) && (q == {ADDR_W{1'b0}}));
    endfunction

    // Hold chain propagates backpressure from the sink towards stage 0; kill
    // marks every stage at or below the highest asserted flush bit.
    always_comb begin : hold_chain
        logic h_v;
        logic k_v;
        hold_s = {DEPTH{1'b0}};
        kill_s = {DEPTH{1'b0}};
        h_v    = valid_r[DEPTH-1] & (stall_req[DEPTH-1] | ~out_ready);
        k_v    = flush[DEPTH-1];
        hold_s[DEPTH-1] = h_v;
        kill_s[DEPTH-1] = k_v;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            // An empty stage never holds, so younger words collapse into it.
            h_v       = valid_r[i] & (stall_req[i] | h_v);
            k_v       = flush[i] | k_v;
            hold_s[i] = h_v;
            kill_s[i] = k_v;
        end
    end

    assign in_ready_s = ~hold_s[0] & ~(|flush);

    // Stage registers: kill beats hold, hold keeps contents, otherwise shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            wen_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i]  <= {DATA_W{1'b0}};
                waddr_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            if (kill_s[0]) begin
                valid_r[0] <= 1'b0;
            end else if (!hold_s[0]) begin
                valid_r[0] <= in_valid & in_ready_s;
                data_r[0]  <= in_data;
                wen_r[0]   <= in_wen;
                waddr_r[0] <= in_waddr;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (kill_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (!hold_s[i]) begin
                    // A held or killed upstream stage leaves a bubble here.
                    valid_r[i] <= valid_r[i-1] & ~hold_s[i-1] & ~kill_s[i-1];
                    data_r[i]  <= data_r[i-1];
                    wen_r[i]   <= wen_r[i-1];
                    waddr_r[i] <= waddr_r[i-1];
                end
            end
        end
    end

    // Pack per-stage write addresses into the flat status bus.
    always_comb begin
        stage_waddr_s = {(ADDR_W*DEPTH){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            stage_waddr_s[i*ADDR_W +: ADDR_W] = waddr_r[i];
        end
    end

    // Hazard lookup: scan oldest to youngest so the youngest match is left.
    always_comb begin
        logic ma_v;
        logic mb_v;
        hit_a_s       = 1'b0;
        hit_b_s       = 1'b0;
        hit_stage_a_s = {HS_W{1'b0}};
        hit_stage_b_s = {HS_W{1'b0}};
        hit_data_a_s  = {DATA_W{1'b0}};
        hit_data_b_s  = {DATA_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ma_v          = match_f(valid_r[i], wen_r[i], waddr_r[i], query_a);
            mb_v          = match_f(valid_r[i], wen_r[i], waddr_r[i], query_b);
            hit_a_s       = hit_a_s | ma_v;
            hit_b_s       = hit_b_s | mb_v;
            hit_stage_a_s = ma_v ? HS_W'(i) : hit_stage_a_s;
            hit_stage_b_s = mb_v ? HS_W'(i) : hit_stage_b_s;
            hit_data_a_s  = ma_v ? data_r[i] : hit_data_a_s;
            hit_data_b_s  = mb_v ? data_r[i] : hit_data_b_s;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_r[DEPTH-1] & ~stall_req[DEPTH-1] & ~flush[DEPTH-1];
    assign out_data    = data_r[DEPTH-1];
    assign out_wen     = wen_r[DEPTH-1];
    assign out_waddr   = waddr_r[DEPTH-1];
    assign stage_valid = valid_r;
    assign stage_wen   = valid_r & wen_r;
    assign stage_waddr = stage_waddr_s;
    assign hit_a       = hit_a_s;
    assign hit_b       = hit_b_s;
    assign hit_stage_a = hit_stage_a_s;
    assign hit_stage_b = hit_stage_b_s;
    assign hit_data_a  = hit_data_a_s;
    assign hit_data_b  = hit_data_b_s;

endmodule

// File: doc/pipe_stage_track.md
Name: pipe_stage_track

Overview:
- Parametrised chain of DEPTH pipeline registers. Replaces hand-written per-stage EXE/MEM/WB register blocks with one generic elastic pipeline.
- Each stage carries valid, payload and a register-writeback tag (wen, waddr).
- Adds per-stage stall with bubble collapse, ranged flush, and sink backpressure.
- Adds a two-port RAW hazard/forwarding lookup over all in-flight stages, for use by decode-stage hazard logic.

Parameters:
DEPTH, 3, number of register stages (>=2); stage 0 youngest, stage DEPTH-1 oldest
DATA_W, 32, payload width per stage
ADDR_W, 5, register-file address width
ZERO_REG, 1, 1 = address 0 never produces a hazard hit (hardwired zero register)

Ports:
clk  in  1  main clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream word present
in_ready  out  1  stage 0 accepts this cycle
in_data  in  DATA_W  payload
in_wen  in  1  writeback enable tag
in_waddr  in  ADDR_W  writeback address tag
stall_req  in  DEPTH  bit i: word in stage i must not advance
flush  in  DEPTH  bit k: kill stages 0..k
out_valid  out  1  stage DEPTH-1 presenting
out_ready  in  1  sink accepts
out_data  out  DATA_W  stage DEPTH-1 payload
out_wen  out  1  stage DEPTH-1 wen tag
out_waddr  out  ADDR_W  stage DEPTH-1 waddr tag
stage_valid  out  DEPTH  valid of each stage
stage_wen  out  DEPTH  wen of each stage, gated by valid
stage_waddr  out  DEPTH*ADDR_W  stage i at [i*ADDR_W +: ADDR_W]
query_a, query_b  in  ADDR_W  source register addresses to check
hit_a, hit_b  out  1  in-flight producer found
hit_stage_a, hit_stage_b  out  max(1,$clog2(DEPTH))  index of youngest matching stage
hit_data_a, hit_data_b  out  DATA_W  payload of that stage

Behaviour:
- Reset (rst_n=0, immediate, no clock needed): all valid=0, wen=0, data=0, waddr=0. Therefore out_valid=0, stage_valid=0, hit_*=0, hit_stage_*=0, hit_data_*=0. in_ready=1 once no flush is asserted.
- Hold chain, combinational:
  - hold[D-1] = valid[D-1] & (stall_req[D-1] | ~out_ready)
  - hold[i] = valid[i] & (stall_req[i] | hold[i+1])
- An invalid stage never holds. An older stall therefore lets younger words advance into a bubble (bubble collapse). stall_req on an empty stage has no effect.
- Advance at clock edge:
  - A stage with hold=1 keeps its contents.
  - Otherwise stage i (i>0) loads stage i-1 contents with valid = valid[i-1] & ~hold[i-1]. A held upstream leaves a bubble.
  - Stage 0 loads the in_* inputs with valid = in_valid & in_ready.
- in_ready = ~hold[0] & ~(|flush).
- out_valid = valid[D-1] & ~stall_req[D-1] & ~flush[D-1]. Transfer occurs when out_valid & out_ready; stage D-1 empties or refills on that edge.
- Latency: a word accepted at edge n appears on out_* after edge n+DEPTH-1 when nothing holds. Throughput is 1 word/cycle.
- Flush:
  - kmax = highest set flush bit. At the next edge, stages 0..kmax become invalid and stage kmax+1 receives a bubble.
  - Stages above kmax behave normally.
  - Flush beats stall and hold for the flushed stages. Input is refused while any flush is asserted.
- Bubble data: wen/waddr/data of an invalid stage are don't-care internally, but stage_wen is forced 0.
- Hazard lookup, combinational on registered state:
  - match[i] = valid[i] & wen[i] & (waddr[i]==query) & ~(ZERO_REG & query==0).
  - hit = |match. hit_stage = lowest i with match (youngest producer wins). hit_data = data[hit_stage].
  - With no hit, hit_stage=0 and hit_data=0.
- Simultaneous accept and output on one edge with all stages full and no holds is legal; the count of words in flight is unchanged.
- Reset asserted mid-stream discards all words. No partial output.

Test Plan:
1. DEPTH=3, out_ready=1, stream in_data 0x10..0x17 on consecutive cycles. Expect first out_valid after edge 2 following first accept, data 0x10..0x17 in order, one per cycle, in_ready constantly 1.
2. Stages valid {0:1,1:0,2:1}, out_ready=0. Expect one edge: stage 0 moves to stage 1, stage 0 accepts new input. Next cycle in_ready=0, stage_valid=3'b111, out_valid=1 held.
3. DEPTH=4 full, stall_req[1]=1 for 2 cycles. Expect stages 0-1 frozen, stage 2 gets bubbles, stage 3 drains, in_ready=0. Release gives resumed order with no loss or duplication.
4. DEPTH=4 full, flush=4'b0100 with stall_req[2]=1 in the same cycle. Expect next stage_valid=4'b1000 (stage 3 retained) and in_ready=0 that cycle. flush[3] alone forces out_valid=0 that cycle.
5. Stage 1 {wen=1, waddr=5, data=0xAAAA}, stage 2 {wen=1, waddr=5, data=0xBBBB}. Expect query_a=5 → hit_a=1, hit_stage_a=1, hit_data_a=0xAAAA. query_b=0 with stage 0 waddr=0, wen=1 → hit_b=0. Stage with wen=0 or valid=0 and waddr=5 → no hit.
6. Drop rst_n between edges mid-stream. Expect out_valid, stage_valid and hit_* to go 0 immediately. After release, the first accepted word emerges after DEPTH-1 edges.
